// File: rtl/fp32_to_fp16_pkg.sv
// Shared constants, operand classes and stage-1 record for the FP32->FP16 narrowing pipe.
package fp32_to_fp16_pkg;

    localparam int FP32_BIAS  = 127;
    localparam int FP16_BIAS  = 15;
    localparam int FP32_EXP_W = 8;
    localparam int FP16_EXP_W = 5;

    localparam logic [14:0] FP16_INF  = 15'h7C00;
    localparam logic [14:0] FP16_QNAN = 15'h7E00;

    // FP32 biased exponent minus this gives the FP16 biased exponent
    localparam logic signed [9:0] EXP_REBIAS = 10'(FP32_BIAS - FP16_BIAS);
    localparam logic signed [9:0] SH_MAX     = 10'sd26;

    typedef enum logic [2:0] {
        CLS_ZERO  = 3'd0,
        CLS_SUB32 = 3'd1,
        CLS_NORM  = 3'd2,
        CLS_INF   = 3'd3,
        CLS_NAN   = 3'd4
    } fp_class_t;

    typedef struct packed {
        logic             sign;
        fp_class_t        cls;
        logic signed [9:0] e;
        logic [23:0]      sig;
        logic [4:0]       sh;
    } s1_t;

    function automatic fp_class_t classify(input logic [FP32_EXP_W-1:0] exp32,
                                           input logic [22:0] man32);
        fp_class_t c;
        if (exp32 == '0) begin
            if (man32 == '0) c = CLS_ZERO;
            else             c = CLS_SUB32;
        end else if (exp32 == '1) begin
            if (man32 == '0) c = CLS_INF;
            else             c = CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp32_to_fp16_round.sv
// Combinational round-to-nearest-even and pack of one classified FP32 operand into FP16 + flags.
module fp32_to_fp16_round
    import fp32_to_fp16_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b0,
    parameter bit CANON_NAN    = 1'b1
) (
    input  fp_class_t         cls,
    input  logic              sign,
    input  logic signed [9:0] e,
    input  logic [23:0]       sig,
    input  logic [4:0]        sh,
    output logic [15:0]       data16,
    output logic              ovf,
    output logic              unf,
    output logic              inx
);

    logic [9:0]  m;
    logic        g;
    logic        st;
    logic        up;
    logic [14:0] nrm_sum;

    logic [4:0]  sub_sh;
    logic [35:0] sub_ext;
    logic [9:0]  sub_v;
    logic        sub_g;
    logic        sub_st;
    logic        sub_up;
    logic [10:0] sub_r;

    always_comb begin
        m       = sig[22:13];
        g       = sig[12];
        st      = |sig[11:0];
        up      = g & (st | m[0]);
        nrm_sum = {e[FP16_EXP_W-1:0], m} + 15'(up);

        // sh is at least 14 on the subnormal path; the 12 appended zeros absorb the extra shift
        sub_sh  = sh - 5'd14;
        sub_ext = {sig, 12'b0} >> sub_sh;
        sub_v   = sub_ext[35:26];
        sub_g   = sub_ext[25];
        sub_st  = |sub_ext[24:0];
        sub_up  = sub_g & (sub_st | sub_v[0]);
        sub_r   = {1'b0, sub_v} + 11'(sub_up);

        data16 = {sign, 15'h0};
        ovf    = 1'b0;
        unf    = 1'b0;
        inx    = 1'b0;
        case (cls)
            CLS_NAN: begin
                if (CANON_NAN) data16 = {sign, FP16_QNAN};
                else           data16 = {sign, 5'h1F, 1'b1, sig[21:13]};
            end
            CLS_INF: data16 = {sign, FP16_INF};
            CLS_ZERO: data16 = {sign, 15'h0};
            CLS_SUB32: begin
                unf = 1'b1;
                inx = 1'b1;
            end
            default: begin
                if (e >= 10'sd31) begin
                    data16 = {sign, FP16_INF};
                    ovf    = 1'b1;
                    inx    = 1'b1;
                end else if (e > 10'sd0) begin
                    data16 = {sign, nrm_sum};
                    ovf    = (nrm_sum[14:10] == 5'h1F);
                    inx    = g | st;
                end else if (FLUSH_DENORM) begin
                    unf = 1'b1;
                    inx = 1'b1;
                end else begin
                    // a carry into bit 10 lands exactly on the smallest normal encoding
                    data16 = {sign, 4'b0, sub_r};
                    unf    = sub_g | sub_st;
                    inx    = sub_g | sub_st;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp32_to_fp16_pipe.sv
// Two-register FP32->FP16 narrowing pipe: stage 1 classifies, stage 2 holds the rounded result.
module fp32_to_fp16_pipe
    import fp32_to_fp16_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b0,
    parameter bit CANON_NAN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inx
);

    // Valid/ready: a beat moves when valid && ready; a stage loads when it is empty or its
    // downstream moves this cycle, so in_ready follows out_ready combinationally with no bubble.
    logic s1_valid;
    logic s1_adv;
    logic s2_adv;
    s1_t  s1_d;
    s1_t  s1_q;

    logic signed [9:0] e_in;
    logic signed [9:0] sh_full;

    logic [15:0] rnd_data;
    logic        rnd_ovf;
    logic        rnd_unf;
    logic        rnd_inx;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        e_in    = $signed({2'b00, in_data[30:23]}) - EXP_REBIAS;
        sh_full = 10'sd14 - e_in;

        s1_d.sign = in_data[31];
        s1_d.cls  = classify(in_data[30:23], in_data[22:0]);
        s1_d.e    = e_in;
        s1_d.sig  = {1'b1, in_data[22:0]};
        if (sh_full > SH_MAX)       s1_d.sh = SH_MAX[4:0];
        else if (sh_full < 10'sd0)  s1_d.sh = 5'd0;
        else                        s1_d.sh = sh_full[4:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    fp32_to_fp16_round #(
        .FLUSH_DENORM(FLUSH_DENORM),
        .CANON_NAN   (CANON_NAN)
    ) u_round (
        .cls   (s1_q.cls),
        .sign  (s1_q.sign),
        .e     (s1_q.e),
        .sig   (s1_q.sig),
        .sh    (s1_q.sh),
        .data16(rnd_data),
        .ovf   (rnd_ovf),
        .unf   (rnd_unf),
        .inx   (rnd_inx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 16'h0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inx   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= rnd_data;
                out_ovf  <= rnd_ovf;
                out_unf  <= rnd_unf;
                out_inx  <= rnd_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// Bench for fp32_to_fp16_pipe: default instance and a flush/payload-NaN instance share one stimulus stream.
module tb_fp32_to_fp16_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready_a, out_valid_a, ovf_a, unf_a, inx_a;
    logic        in_ready_b, out_valid_b, ovf_b, unf_b, inx_b;
    logic [15:0] out_data_a, out_data_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    logic [18:0] exp_a[$];
    logic [18:0] exp_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp32_to_fp16_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ovf(ovf_a), .out_unf(unf_a), .out_inx(inx_a)
    );

    fp32_to_fp16_pipe #(.FLUSH_DENORM(1'b1), .CANON_NAN(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ovf(ovf_b), .out_unf(unf_b), .out_inx(inx_b)
    );

    // Value-level reference: result = mant * 2^(exp-150), requantised to the FP16 ulp of its binade.
    function automatic logic [18:0] model(input logic [31:0] x, input bit canon, input bit flush);
        bit          s;
        int          ex, e16, k;
        longint      mant, n, rem, half;
        logic [15:0] r;
        bit          ovf, unf, inx, tiny;
        s    = x[31];
        ex   = int'(x[30:23]);
        mant = longint'(x[22:0]);
        ovf  = 0; unf = 0; inx = 0;
        r    = {s, 15'h0};
        if (ex == 255) begin
            if (mant != 0) r = canon ? {s, 15'h7E00} : {s, 5'h1F, 1'b1, x[21:13]};
            else           r = {s, 15'h7C00};
        end else if (ex == 0) begin
            if (mant != 0) begin unf = 1; inx = 1; end
        end else begin
            mant = mant + (longint'(1) << 23);
            tiny = (ex - 127) < -14;
            if (ex - 127 > 15) begin
                r = {s, 15'h7C00}; ovf = 1; inx = 1;
            end else if (tiny && flush) begin
                unf = 1; inx = 1;
            end else begin
                e16 = tiny ? -14 : ex - 127;
                k   = (e16 - 10) - (ex - 150);
                if (k > 40) begin
                    n = 0; rem = 1; half = longint'(1) << 40;
                end else begin
                    n    = mant >> k;
                    rem  = mant - (n << k);
                    half = longint'(1) << (k - 1);
                end
                inx = (rem != 0);
                if (rem > half || (rem == half && (n % 2) == 1)) n = n + 1;
                if (n == 2048) begin n = 1024; e16 = e16 + 1; end
                if (e16 > 15) begin
                    r = {s, 15'h7C00}; ovf = 1; inx = 1;
                end else if (n < 1024) begin
                    r = {s, 15'(n)};
                end else begin
                    r = {s, 5'(e16 + 15), 10'(n - 1024)};
                end
                unf = tiny && inx;
            end
        end
        return {r, ovf, unf, inx};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: accepted inputs queue expectations, every valid output cycle is compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready_match", {31'b0, in_ready_b}, {31'b0, in_ready_a});
            if (out_valid_a) begin
                if (exp_a.size() == 0) chk("spurious_a", {31'b0, out_valid_a}, 32'd0);
                else begin
                    chk("dut_a", {13'b0, out_data_a, ovf_a, unf_a, inx_a}, {13'b0, exp_a[0]});
                    if (out_ready) void'(exp_a.pop_front());
                end
            end
            if (out_valid_b) begin
                if (exp_b.size() == 0) chk("spurious_b", {31'b0, out_valid_b}, 32'd0);
                else begin
                    chk("dut_b", {13'b0, out_data_b, ovf_b, unf_b, inx_b}, {13'b0, exp_b[0]});
                    if (out_ready) void'(exp_b.pop_front());
                end
            end
            if (in_valid && in_ready_a) begin
                exp_a.push_back(model(in_data, 1'b1, 1'b0));
                exp_b.push_back(model(in_data, 1'b0, 1'b1));
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_a.size() + exp_b.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // {input, fp16 result, ovf, unf, inx} for the default instance
    logic [50:0] vec_a[15] = '{
        {32'h3F800000, 16'h3C00, 3'b000},
        {32'h477FE000, 16'h7BFF, 3'b000},
        {32'h477FF000, 16'h7C00, 3'b101},
        {32'hFF800000, 16'hFC00, 3'b000},
        {32'h3F801000, 16'h3C00, 3'b001},
        {32'h3F803000, 16'h3C02, 3'b001},
        {32'h33800000, 16'h0001, 3'b000},
        {32'h33000000, 16'h0000, 3'b011},
        {32'h33000001, 16'h0001, 3'b011},
        {32'h387FE000, 16'h0400, 3'b011},
        {32'h7FC00001, 16'h7E00, 3'b000},
        {32'h80000001, 16'h8000, 3'b011},
        {32'h00000000, 16'h0000, 3'b000},
        {32'hC0490FDB, 16'hC248, 3'b001},
        {32'h47800000, 16'h7C00, 3'b101}
    };

    // same layout for the FLUSH_DENORM=1, CANON_NAN=0 instance
    logic [50:0] vec_b[4] = '{
        {32'hFFA00000, 16'hFF00, 3'b000},
        {32'h33800000, 16'h0000, 3'b011},
        {32'h387FE000, 16'h0000, 3'b011},
        {32'h3F801000, 16'h3C00, 3'b001}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [50:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
        chk("rst_out_a", {13'b0, out_data_a, ovf_a, unf_a, inx_a}, 32'd0);
        chk("rst_out_valid_b", {31'b0, out_valid_b}, 32'd0);
        chk("rst_out_b", {13'b0, out_data_b, ovf_b, unf_b, inx_b}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'b0, in_ready_a}, 32'd1);

        foreach (vec_a[i]) begin
            v = vec_a[i];
            chk("model_a", {13'b0, model(v[50:19], 1'b1, 1'b0)}, {13'b0, v[18:0]});
        end
        foreach (vec_b[i]) begin
            v = vec_b[i];
            chk("model_b", {13'b0, model(v[50:19], 1'b0, 1'b1)}, {13'b0, v[18:0]});
        end

        @(posedge clk);
        #1;
        send(32'h3F800000);
        n = 0;
        @(negedge clk);
        while (!out_valid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", cyc - last_acc_cyc, 32'd2);
        drain();

        foreach (vec_a[i]) begin
            v = vec_a[i];
            send(v[50:19]);
        end
        foreach (vec_b[i]) begin
            v = vec_b[i];
            send(v[50:19]);
        end
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    v = vec_a[i];
                    send(v[50:19]);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready_a}, 32'd0);
                    chk("stall_out_valid", {31'b0, out_valid_a}, 32'd1);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h3F800000);
        send(32'h3F803000);
        send(32'h477FF000);
        #1;
        chk("pre_reset_valid", {31'b0, out_valid_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid_a", {31'b0, out_valid_a}, 32'd0);
        chk("mid_reset_valid_b", {31'b0, out_valid_b}, 32'd0);
        chk("mid_reset_out_a", {13'b0, out_data_a, ovf_a, unf_a, inx_a}, 32'd0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_idle", {31'b0, out_valid_a}, 32'd0);
        @(posedge clk);
        #1;
        send(32'hC0490FDB);
        send(32'h33000001);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
